// File: rtl/mdu_iter_pkg.sv
// rtl/mdu_iter_pkg.sv - shared encodings and helpers for the iterative multiply/divide unit
package mdu_iter_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    // Wide enough for any iteration count up to 63
    localparam int CNT_W = 6;

    // Divide-by-zero yields an all-ones quotient; remainder is the raw dividend
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    // Magnitude of a two's-complement word when sgn is set, raw value otherwise
    function automatic logic [31:0] abs32(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// rtl/mdu_div_iter.sv - radix-2 restoring divider, one quotient bit per cycle
module mdu_div_iter
    import mdu_iter_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sgn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0]      rem_q, quo_q, dvs_q;
    logic             neg_q_q, neg_r_q, active_q;
    logic [CNT_W-1:0] step_q;

    logic [32:0]      shifted;
    logic             ge;
    logic [31:0]      rem_n, quo_n;

    // One restoring step; outputs reflect the result after the current step so the
    // caller can capture the final value on the last iteration cycle
    always_comb begin
        shifted   = {rem_q, quo_q[31]};
        ge        = (shifted >= {1'b0, dvs_q});
        rem_n     = ge ? (shifted[31:0] - dvs_q) : shifted[31:0];
        quo_n     = {quo_q[30:0], ge};
        quotient  = neg_q_q ? (~quo_n + 32'd1) : quo_n;
        remainder = neg_r_q ? (~rem_n + 32'd1) : rem_n;
        done      = active_q && (step_q == CNT_W'(DIV_CYCLES - 1));
    end

    // Load magnitudes and sign fix-up flags on start, then shift one bit per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            active_q <= 1'b0;
            step_q   <= '0;
        end else if (start) begin
            rem_q    <= '0;
            quo_q    <= abs32(a, sgn);
            dvs_q    <= abs32(b, sgn);
            neg_q_q  <= sgn && (a[31] ^ b[31]);
            neg_r_q  <= sgn && a[31];
            active_q <= 1'b1;
            step_q   <= '0;
        end else if (active_q) begin
            rem_q  <= rem_n;
            quo_q  <= quo_n;
            step_q <= step_q + CNT_W'(1);
            if (done) active_q <= 1'b0;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - multi-cycle MULT/MULTU/DIV/DIVU unit with MTHI/MTLO pass-through
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdu_stall_i,
    input  logic        mdu_flush_i,
    input  logic        mdu_valid_i,
    input  logic [2:0]  mdu_op_i,
    input  logic [31:0] mdu_a_i,
    input  logic [31:0] mdu_b_i,
    output logic [31:0] mdu_hi_o,
    output logic [31:0] mdu_lo_o,
    output logic        mdu_whien_o,
    output logic        mdu_wloen_o,
    output logic        mdu_stallreq_o,
    output logic        mdu_busy_o
);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q, lo_q;
    logic             mt_hi_q, mt_lo_q;
    logic [31:0]      mul_a_q, mul_b_q, div_a_q;
    logic             mul_sgn_q, div_zero_q;

    logic             accept, is_mul, is_div;
    logic [63:0]      product_c, prod_res;
    logic             div_done;
    logic [31:0]      div_quo, div_rem;

    // Accept decode and stall request; flush always wins over a new op
    always_comb begin
        accept = (state_q == ST_IDLE) && mdu_valid_i && !mdu_flush_i && (mdu_op_i != MDU_NONE);
        is_mul = (mdu_op_i == MDU_MULT) || (mdu_op_i == MDU_MULTU);
        is_div = (mdu_op_i == MDU_DIV)  || (mdu_op_i == MDU_DIVU);
        unique case (state_q)
            ST_IDLE: mdu_stallreq_o = accept && (is_mul || is_div);
            ST_MUL,
            ST_DIV:  mdu_stallreq_o = 1'b1;
            ST_DONE: mdu_stallreq_o = mdu_stall_i;
            default: mdu_stallreq_o = 1'b0;
        endcase
    end

    // Sign- or zero-extend to 64 bits so the low half of one product serves both forms
    always_comb begin
        product_c = {{32{mul_sgn_q & mul_a_q[31]}}, mul_a_q} *
                    {{32{mul_sgn_q & mul_b_q[31]}}, mul_b_q};
    end

    generate
        if (MUL_CYCLES == 1) begin : g_mul_comb
            assign prod_res = product_c;
        end else begin : g_mul_pipe
            logic [63:0] stage [MUL_CYCLES-1];
            // Product pipeline, one stage per extra multiply cycle
            always_ff @(posedge clk) begin
                stage[0] <= product_c;
                for (int i = 1; i < MUL_CYCLES - 1; i++) stage[i] <= stage[i-1];
            end
            assign prod_res = stage[MUL_CYCLES-2];
        end
    endgenerate

    mdu_div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk       (clk),
        .rst       (rst_n),
        .start     (accept && is_div),
        .sgn       (mdu_op_i == MDU_DIV),
        .a         (mdu_a_i),
        .b         (mdu_b_i),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Control FSM: accept, iterate, then present the result until the pipeline takes it
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            mt_hi_q    <= 1'b0;
            mt_lo_q    <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_sgn_q  <= 1'b0;
            div_a_q    <= '0;
            div_zero_q <= 1'b0;
        end else if (mdu_flush_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mt_hi_q <= 1'b0;
            mt_lo_q <= 1'b0;
        end else begin
            mt_hi_q <= 1'b0;
            mt_lo_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state_q   <= ST_MUL;
                            cnt_q     <= CNT_W'(MUL_CYCLES - 1);
                            mul_a_q   <= mdu_a_i;
                            mul_b_q   <= mdu_b_i;
                            mul_sgn_q <= (mdu_op_i == MDU_MULT);
                        end else if (is_div) begin
                            state_q    <= ST_DIV;
                            cnt_q      <= CNT_W'(DIV_CYCLES - 1);
                            div_a_q    <= mdu_a_i;
                            div_zero_q <= (mdu_b_i == 32'd0);
                        end else if (mdu_op_i == MDU_MTHI) begin
                            hi_q    <= mdu_a_i;
                            mt_hi_q <= 1'b1;
                        end else if (mdu_op_i == MDU_MTLO) begin
                            lo_q    <= mdu_a_i;
                            mt_lo_q <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (cnt_q == '0) begin
                        {hi_q, lo_q} <= prod_res;
                        state_q      <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
                    if (div_done) begin
                        hi_q    <= div_zero_q ? div_a_q : div_rem;
                        lo_q    <= div_zero_q ? DIV0_LO : div_quo;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!mdu_stall_i) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mdu_hi_o    = hi_q;
    assign mdu_lo_o    = lo_q;
    assign mdu_busy_o  = (state_q != ST_IDLE);
    assign mdu_whien_o = ((state_q == ST_DONE) && !mdu_stall_i && !mdu_flush_i) || mt_hi_q;
    assign mdu_wloen_o = ((state_q == ST_DONE) && !mdu_stall_i && !mdu_flush_i) || mt_lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - randomized self-checking bench for mdu_iter against an arithmetic model
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, valid = 1'b0;
    logic [2:0]  op = MDU_NONE;
    logic [31:0] a = '0, b = '0;
    logic [31:0] hi, lo;
    logic        whien, wloen, stallreq, busy;

    int total = 0;
    int bad = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    always #5 clk = ~clk;

    mdu_iter #(.MUL_CYCLES(2), .DIV_CYCLES(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mdu_stall_i    (stall),
        .mdu_flush_i    (flush),
        .mdu_valid_i    (valid),
        .mdu_op_i       (op),
        .mdu_a_i        (a),
        .mdu_b_i        (b),
        .mdu_hi_o       (hi),
        .mdu_lo_o       (lo),
        .mdu_whien_o    (whien),
        .mdu_wloen_o    (wloen),
        .mdu_stallreq_o (stallreq),
        .mdu_busy_o     (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference results straight from the arithmetic definition of each op
    task automatic ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                             output logic [31:0] rh, output logic [31:0] rl);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        rh = m_hi;
        rl = m_lo;
        case (o)
            MDU_MULT:  begin p = 64'(sx * sy); {rh, rl} = p; end
            MDU_MULTU: begin p = {32'd0, x} * {32'd0, y}; {rh, rl} = p; end
            MDU_DIV, MDU_DIVU: begin
                if (y == 0) begin
                    rl = 32'hFFFF_FFFF;
                    rh = x;
                end else begin
                    if (o == MDU_DIVU) begin
                        q = longint'({32'd0, x}) / longint'({32'd0, y});
                        r = longint'({32'd0, x}) % longint'({32'd0, y});
                    end else begin
                        q = sx / sy;
                        r = sx % sy;
                    end
                    rl = q[31:0];
                    rh = r[31:0];
                end
            end
            MDU_MTHI: rh = x;
            MDU_MTLO: rl = x;
            default: ;
        endcase
    endtask

    // Issue one op and follow it cycle by cycle until its write pulse
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int nstall);
        logic [31:0] eh, el;
        bit md;
        int lat, done_k;
        ref_model(o, x, y, eh, el);
        md  = (o == MDU_MULT) || (o == MDU_MULTU) || (o == MDU_DIV) || (o == MDU_DIVU);
        lat = ((o == MDU_MULT) || (o == MDU_MULTU)) ? MUL_LAT : DIV_LAT;
        @(negedge clk);
        valid = 1'b1; op = o; a = x; b = y; stall = 1'b0;
        #1;
        check("acc_stallreq", stallreq, md);
        check("acc_busy", busy, 0);
        @(negedge clk);
        valid = 1'b0; op = MDU_NONE;
        if (!md) begin
            #1;
            check("mt_whien", whien, o == MDU_MTHI);
            check("mt_wloen", wloen, o == MDU_MTLO);
            check("mt_result", {hi, lo}, {eh, el});
            check("mt_stallreq", stallreq, 0);
            check("mt_busy", busy, 0);
            m_hi = eh; m_lo = el;
            return;
        end
        done_k = lat + nstall;
        for (int k = 1; k <= done_k; k++) begin
            stall = (k >= lat) && (k < done_k);
            #1;
            check("stallreq", stallreq, k < done_k);
            check("busy", busy, 1);
            check("whien", whien, k == done_k);
            check("wloen", wloen, k == done_k);
            if (k >= lat) check("result", {hi, lo}, {eh, el});
            else          check("held", {hi, lo}, {m_hi, m_lo});
            if (k < done_k) @(negedge clk);
        end
        stall = 1'b0;
        m_hi = eh; m_lo = el;
    endtask

    // Start a divide and kill it at cycle 10 by flush or by reset
    task automatic abort_op(input bit use_reset);
        bit pulsed;
        @(negedge clk);
        valid = 1'b1; op = MDU_DIV; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        valid = 1'b0; op = MDU_NONE;
        for (int k = 1; k < 10; k++) @(negedge clk);
        if (use_reset) rst_n = 1'b1; else flush = 1'b1;
        @(negedge clk);
        rst_n = 1'b0; flush = 1'b0;
        #1;
        if (use_reset) begin m_hi = '0; m_lo = '0; end
        check(use_reset ? "rst_busy" : "flush_busy", busy, 0);
        check(use_reset ? "rst_stallreq" : "flush_stallreq", stallreq, 0);
        check(use_reset ? "rst_result" : "flush_result", {hi, lo}, {m_hi, m_lo});
        pulsed = whien | wloen;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            pulsed |= whien | wloen | busy;
        end
        check(use_reset ? "rst_no_pulse" : "flush_no_pulse", pulsed, 0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_out", {hi, lo, whien, wloen, stallreq, busy}, 0);

        run_op(MDU_MULT,  32'hFFFF_FFFE, 32'd3, 0);
        run_op(MDU_DIVU,  32'd100, 32'd7, 0);
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2, 0);
        run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(MDU_DIVU,  32'd5, 32'd0, 0);
        run_op(MDU_DIV,   32'hFFFF_FFF0, 32'd0, 0);
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4);
        run_op(MDU_MTHI,  32'h0000_1234, 32'd0, 0);
        run_op(MDU_MTLO,  32'hCAFE_0001, 32'd0, 0);

        abort_op(1'b0);
        abort_op(1'b1);

        // Flush in the same cycle as a valid op: the op must not be taken
        @(negedge clk);
        valid = 1'b1; flush = 1'b1; op = MDU_MULT; a = 32'd9; b = 32'd9;
        @(negedge clk);
        valid = 1'b0; flush = 1'b0; op = MDU_NONE;
        #1;
        check("flush_vs_accept", busy, 0);

        for (int n = 0; n < 40; n++) begin
            ro = 3'($urandom_range(1, 6));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
                2: ry = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(ro, rx, ry, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
